// File: rtl/aram_fifo_rd_wr_ctl_64x544.sv
// aram_fifo_rd_wr_ctl_64x544
// Single-clock FIFO controller that writes and reads an external 1r1w RAM.
// Flits pushed on i_* are written into the RAM. Reads are issued early enough
// that the one-cycle RAM read latency is absorbed by a two-entry output buffer.
// The buffer head is shown first-word-fall-through on o_*, at up to one flit
// per cycle.

module aram_fifo_rd_wr_ctl_64x544 #(
    parameter int WIDTH = 544,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,

    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,

    output logic             ram_ena,
    output logic             ram_wea,
    output logic [AW-1:0]    ram_addra,
    output logic [WIDTH-1:0] ram_dia,
    output logic             ram_enb,
    output logic [AW-1:0]    ram_addrb,
    input  logic [WIDTH-1:0] ram_dob,

    output logic [AW:0]      count
);

    // Number of RAM entries, held at the width of the RAM occupancy counter.
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    // RAM-side state.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic          rd_inflight;

    // Output buffer state. ob0 is always the head.
    logic [1:0]       ob_cnt;
    logic [1:0]       ob_cnt_nxt;
    logic [1:0]       ob_kept;
    logic [WIDTH-1:0] ob0;
    logic [WIDTH-1:0] ob1;

    // Per-cycle events.
    logic       push;
    logic       pop;
    logic       rd;
    logic [2:0] ob_occ;
    logic [AW:0] count_nxt;

    // Handshake decode. Only registered state is used, so i_ready and o_valid
    // are free of combinational paths from the inputs.
    assign i_ready = (ram_cnt != DEPTH);
    assign o_valid = (ob_cnt != 2'd0);
    assign o_data  = ob0;
    assign push    = i_valid & i_ready;
    assign pop     = o_valid & o_ready;

    // RAM ports. The strobes are held off while reset is asserted, so nothing
    // is written or read while the controller state is being cleared.
    assign ram_ena   = push & ~reset;
    assign ram_wea   = ram_ena;
    assign ram_addra = wr_ptr;
    assign ram_dia   = i_data;
    assign ram_enb   = rd & ~reset;
    assign ram_addrb = rd_ptr;

    // Decide whether to read, and compute the next occupancy values.
    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        rd          = 1'b0;
        ob_occ      = {1'b0, ob_cnt} + {2'b00, rd_inflight};
        ob_kept     = ob_cnt - {1'b0, pop};
        ram_cnt_nxt = ram_cnt;
        ob_cnt_nxt  = ob_cnt;
        count_nxt   = count;

        // Read only if the flit can be placed. Buffered flits, plus the
        // in-flight flit, minus this cycle's pop, must leave a free slot
        // when the read data returns.
        if ((ram_cnt != '0) && (ob_occ <= ({2'b00, pop} + 3'd1)))
            rd = 1'b1;

        ram_cnt_nxt = ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd};
        ob_cnt_nxt  = ob_kept + {1'b0, rd_inflight};
        count_nxt   = ram_cnt_nxt + {{AW{1'b0}}, rd} + {{(AW-1){1'b0}}, ob_cnt_nxt};
    end

    // Pointers, occupancy counters and the registered total count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            ob_cnt      <= 2'd0;
            count       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // register then samples the values from before the edge, whatever
            // order the statements are written in.
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd)
                rd_ptr <= rd_ptr + AW'(1);
            ram_cnt     <= ram_cnt_nxt;
            rd_inflight <= rd;
            ob_cnt      <= ob_cnt_nxt;
            count       <= count_nxt;
        end
    end

    // Output buffer data. On a pop, entry1 moves to the head. Returning RAM
    // data goes into the first slot that is free after the pop. The head does
    // not change while it is valid and stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: these two data registers are reset because o_data must
            // read zero out of reset. The RAM array is external and is never
            // cleared.
            ob0 <= '0;
            ob1 <= '0;
        end else begin
            if (pop && (ob_cnt == 2'd2))
                ob0 <= ob1;
            if (rd_inflight) begin
                if (ob_kept == 2'd0)
                    ob0 <= ram_dob;
                else
                    ob1 <= ram_dob;
            end
        end
    end

endmodule
